// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: prefetch queue feeding decode from a zero-wait instruction memory
//   clk_i/rst_ni            clock, asynchronous active-low reset
//   fetch_en_i              permit new fetches
//   redirect_valid_i/pc_i   branch/jump redirect pulse and target
//   imem_addr_o/imem_data_i instruction memory address and combinational read data
//   instr_valid_o/ready_i   head handshake with decode
//   instr_o/instr_pc_o      head instruction and its byte address (0 when empty)
//   count_o/state_o         occupancy and FSM state (00 IDLE, 01 RUN, 10 DRAIN)
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     fetch_en_i,
   input  logic                     redirect_valid_i,
   input  logic [31:0]              redirect_pc_i,
   output logic [31:0]              imem_addr_o,
   input  logic [31:0]              imem_data_i,
   output logic                     instr_valid_o,
   input  logic                     instr_ready_i,
   output logic [31:0]              instr_o,
   output logic [31:0]              instr_pc_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [1:0]               state_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DRAIN = 2'b10} state_t;
   state_t        state_q, state_d;
   logic [29:0]   pc_q, pc_d;
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;
   logic [31:0]   data_q [DEPTH];
   logic [29:0]   pca_q [DEPTH];
   // Redirect outranks everything: it flushes, cancels the pop and blocks the push.
   always_comb begin
      pop     = instr_valid_o & instr_ready_i & ~redirect_valid_i;
      push    = (state_q == RUN) & ~redirect_valid_i & ((count_q != FULL) | pop);
      pc_d    = redirect_valid_i ? redirect_pc_i[31:2] : push ? pc_q + 30'd1 : pc_q;
      wptr_d  = redirect_valid_i ? '0 : push ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = redirect_valid_i ? '0 : pop ? rptr_q + AW'(1) : rptr_q;
      count_d = redirect_valid_i ? '0 : count_q + CW'(push) - CW'(pop);
      state_d = state_q == IDLE ? ((fetch_en_i & ~redirect_valid_i) ? RUN : IDLE) :
                state_q == RUN  ? (fetch_en_i ? RUN : DRAIN) :
                fetch_en_i      ? RUN : (count_d == '0 ? IDLE : DRAIN);
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC[31:2];
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end
   // Storage is not reset; only pointers and occupancy decide what is visible.
   always_ff @(posedge clk_i) begin
      if (push) begin
         data_q[wptr_q] <= imem_data_i;
         pca_q[wptr_q]  <= pc_q;
      end
   end
   assign imem_addr_o   = {pc_q, 2'b00};
   assign instr_valid_o = count_q != '0;
   assign instr_o       = instr_valid_o ? data_q[rptr_q] : 32'h0;
   assign instr_pc_o    = instr_valid_o ? {pca_q[rptr_q], 2'b00} : 32'h0;
   assign count_o       = count_q;
   assign state_o       = state_q;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed and random stimulus against a queue-based reference model
module tb_instr_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en, redirect_valid, instr_ready;
   logic [31:0] redirect_pc, imem_addr, imem_data, instr, instr_pc;
   logic        instr_valid;
   logic [2:0]  count;
   logic [1:0]  state;
   int          checks = 0;
   int          failures = 0;
   logic [31:0] q_pc [$];
   logic [31:0] q_dat [$];
   logic [31:0] m_pc;
   int          m_state;
   instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk_i(clk), .rst_ni(rst_n), .fetch_en_i(fetch_en),
      .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
      .imem_addr_o(imem_addr), .imem_data_i(imem_data),
      .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
      .instr_o(instr), .instr_pc_o(instr_pc), .count_o(count), .state_o(state)
   );
   always #5 clk = ~clk;
   assign imem_data = (imem_addr >> 2) * 32'd3;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic chk_all(input string tag);
      chk({tag, ".count"}, {29'd0, count}, q_pc.size());
      chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, q_pc.size() != 0});
      chk({tag, ".instr"}, instr, q_pc.size() != 0 ? q_dat[0] : 32'h0);
      chk({tag, ".instr_pc"}, instr_pc, q_pc.size() != 0 ? q_pc[0] : 32'h0);
      chk({tag, ".imem_addr"}, imem_addr, m_pc);
      chk({tag, ".state"}, {30'd0, state}, m_state);
   endtask
   task automatic model_reset();
      q_pc.delete();
      q_dat.delete();
      m_pc = RESET_PC;
      m_state = 0;
   endtask
   task automatic step(input string tag, input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy);
      bit do_pop, do_push;
      fetch_en = fe;
      redirect_valid = rv;
      redirect_pc = rpc;
      instr_ready = rdy;
      do_pop = q_pc.size() != 0 && rdy && !rv;
      do_push = m_state == 1 && !rv && (q_pc.size() < DEPTH || do_pop);
      if (rv) begin
         q_pc.delete();
         q_dat.delete();
         m_pc = rpc & ~32'd3;
      end else begin
         if (do_pop) begin
            void'(q_pc.pop_front());
            void'(q_dat.pop_front());
         end
         if (do_push) begin
            q_pc.push_back(m_pc);
            q_dat.push_back((m_pc / 4) * 3);
            m_pc = m_pc + 32'd4;
         end
      end
      if (m_state == 0) m_state = (fe && !rv) ? 1 : 0;
      else if (m_state == 1) m_state = fe ? 1 : 2;
      else m_state = fe ? 1 : (q_pc.size() == 0 ? 0 : 2);
      @(posedge clk);
      #1;
      chk_all(tag);
   endtask
   initial begin
      rst_n = 1'b0;
      fetch_en = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = 32'h0;
      instr_ready = 1'b0;
      model_reset();
      #1;
      chk_all("reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) step("stream", 1, 0, 0, 1);
      model_reset();
      rst_n = 1'b0;
      #1;
      chk_all("reset2");
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 9; i++) step("full_hold", 1, 0, 0, 0);
      chk("full_addr", imem_addr, 32'h10);
      step("pop_one", 1, 0, 0, 1);
      step("redirect", 1, 1, 32'h0000_0103, 0);
      step("after_redir", 1, 0, 0, 0);
      chk("redir_instr", instr, 32'd192);
      chk("redir_pc", instr_pc, 32'h100);
      for (int i = 0; i < 4; i++) step("refill", 1, 0, 0, 0);
      for (int i = 0; i < 7; i++) step("drain", 0, 0, 0, 1);
      step("idle_redir", 1, 1, 32'hFFFF_FFFE, 0);
      for (int i = 0; i < 4; i++) step("wrap", 1, 0, 0, 1);
      for (int i = 0; i < 3; i++) step("fill3", 1, 0, 0, 0);
      step("hold3", 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_all("async_reset");
      #2;
      rst_n = 1'b1;
      step("post_reset", 1, 0, 0, 1);
      step("post_reset2", 1, 0, 0, 1);
      for (int i = 0; i < 400; i++)
         step("random", $urandom_range(7, 0) != 0, $urandom_range(15, 0) == 0,
              $urandom(), $urandom_range(2, 0) != 0);
      for (int i = 0; i < 10; i++) step("final_drain", 0, 0, 0, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
